// File: rtl/switch_ingress_arb_if.sv
// Ingress bundle between the two packet sources, the arbiter and the switch input.
// slave is the arbiter side; master is the side that drives sources and watches the switch port.
interface switch_ingress_arb_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  s0_vld;
  logic                  s0_rdy;
  logic [ADDR_WIDTH-1:0] s0_addr;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s1_vld;
  logic                  s1_rdy;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  vld;
  logic [LW-1:0]         s0_level;
  logic [LW-1:0]         s1_level;

  modport slave (
    input  s0_vld, s0_addr, s0_data, s1_vld, s1_addr, s1_data,
    output s0_rdy, s1_rdy, addr, data, vld, s0_level, s1_level
  );

  modport master (
    output s0_vld, s0_addr, s0_data, s1_vld, s1_addr, s1_data,
    input  s0_rdy, s1_rdy, addr, data, vld, s0_level, s1_level
  );
endinterface

// File: rtl/switch_ingress_arb.sv
// Two-source ingress stage: a FIFO per source, merged by a round-robin arbiter
// into the registered addr/data/vld stream the switch consumes.
module switch_ingress_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rstn,
  switch_ingress_arb_if.slave bus
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int PKT = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  logic [PKT-1:0]        mem0 [FIFO_DEPTH];
  logic [PKT-1:0]        mem1 [FIFO_DEPTH];
  logic [PW-1:0]         wp0, rp0, wp1, rp1;
  logic [LW-1:0]         lvl0, lvl1, lvl0_nxt, lvl1_nxt;
  logic                  rdy0_q, rdy1_q;
  logic                  last_grant;
  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  push0, push1, pop0, pop1;
  logic [PKT-1:0]        head0, head1;

  assign push0 = bus.s0_vld & rdy0_q;
  assign push1 = bus.s1_vld & rdy1_q;
  assign head0 = mem0[rp0];
  assign head1 = mem1[rp1];

  // Arbitration looks only at pre-edge levels, so a freshly pushed packet cannot bypass its FIFO.
  always_comb begin
    pop0     = 1'b0;
    pop1     = 1'b0;
    lvl0_nxt = lvl0;
    lvl1_nxt = lvl1;
    if ((lvl0 != '0) && (lvl1 != '0)) begin
      pop0 = last_grant;
      pop1 = ~last_grant;
    end else begin
      pop0 = (lvl0 != '0);
      pop1 = (lvl1 != '0);
    end
    lvl0_nxt = lvl0 + LW'(push0) - LW'(pop0);
    lvl1_nxt = lvl1 + LW'(push1) - LW'(pop1);
  end

  always_ff @(posedge clk) begin
    if (push0) mem0[wp0] <= {bus.s0_addr, bus.s0_data};
    if (push1) mem1[wp1] <= {bus.s1_addr, bus.s1_data};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp0        <= '0;
      rp0        <= '0;
      wp1        <= '0;
      rp1        <= '0;
      lvl0       <= '0;
      lvl1       <= '0;
      rdy0_q     <= 1'b0;
      rdy1_q     <= 1'b0;
      last_grant <= 1'b1;
      vld_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      lvl0   <= lvl0_nxt;
      lvl1   <= lvl1_nxt;
      rdy0_q <= (lvl0_nxt < FULL);
      rdy1_q <= (lvl1_nxt < FULL);
      if (push0) wp0 <= wp0 + PW'(1);
      if (push1) wp1 <= wp1 + PW'(1);
      if (pop0) begin
        rp0        <= rp0 + PW'(1);
        last_grant <= 1'b0;
        vld_q      <= 1'b1;
        {addr_q, data_q} <= head0;
      end else if (pop1) begin
        rp1        <= rp1 + PW'(1);
        last_grant <= 1'b1;
        vld_q      <= 1'b1;
        {addr_q, data_q} <= head1;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.s0_rdy   = rdy0_q;
  assign bus.s1_rdy   = rdy1_q;
  assign bus.vld      = vld_q;
  assign bus.addr     = addr_q;
  assign bus.data     = data_q;
  assign bus.s0_level = lvl0;
  assign bus.s1_level = lvl1;
endmodule

// File: tb/tb_switch_ingress_arb.sv
// Bench for switch_ingress_arb: per-source scoreboards fed on accepted handshakes,
// drained by a monitor on the switch-side output; one task per scenario.
module tb_switch_ingress_arb;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  switch_ingress_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus ();

  switch_ingress_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp0 [$];
  logic [AW+DW-1:0] exp1 [$];
  logic [AW+DW-1:0] mon_got, mon_exp;

  // Source 0 packets use addr[7]=0, source 1 packets addr[7]=1, so the monitor can route them.
  always @(posedge clk) begin
    if (rstn !== 1'b1) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (bus.s0_vld === 1'b1 && bus.s0_rdy === 1'b1) exp0.push_back({bus.s0_addr, bus.s0_data});
      if (bus.s1_vld === 1'b1 && bus.s1_rdy === 1'b1) exp1.push_back({bus.s1_addr, bus.s1_data});
    end
  end

  always @(negedge clk) begin
    if (bus.vld === 1'b1) begin
      mon_got = {bus.addr, bus.data};
      checks++;
      if (mon_got[AW+DW-1]) begin
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL mon_s1_unexpected got=%h required=none", mon_got);
        end else begin
          mon_exp = exp1.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL mon_s1_pkt got=%h required=%h", mon_got, mon_exp);
          end
        end
      end else begin
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL mon_s0_unexpected got=%h required=none", mon_got);
        end else begin
          mon_exp = exp0.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL mon_s0_pkt got=%h required=%h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.s0_vld = 1'b0;
    bus.s1_vld = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle_inputs();
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL %s_drain left s0=%0d s1=%0d required=0", name, exp0.size(), exp1.size());
    end
  endtask

  task automatic test_reset();
    bus.s0_vld = 1'b1; bus.s0_addr = 8'h01; bus.s0_data = 16'h0101;
    bus.s1_vld = 1'b1; bus.s1_addr = 8'h81; bus.s1_data = 16'h8181;
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b required=0", bus.vld); end
    checks++;
    if (bus.addr !== 8'h00 || bus.data !== 16'h0000) begin
      errors++; $display("FAIL rst_addr_data got=%h/%h required=00/0000", bus.addr, bus.data);
    end
    checks++;
    if (bus.s0_rdy !== 1'b0 || bus.s1_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_rdy got=%b%b required=00", bus.s0_rdy, bus.s1_rdy);
    end
    checks++;
    if (bus.s0_level !== '0 || bus.s1_level !== '0) begin
      errors++; $display("FAIL rst_level got=%0d/%0d required=0/0", bus.s0_level, bus.s1_level);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.s0_rdy !== 1'b1 || bus.s1_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_release_rdy got=%b%b required=11", bus.s0_rdy, bus.s1_rdy);
    end
    checks++;
    if (bus.s0_level !== '0 || bus.s1_level !== '0) begin
      errors++; $display("FAIL rst_release_level got=%0d/%0d required=0/0", bus.s0_level, bus.s1_level);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    bus.s0_vld = 1'b1; bus.s0_addr = 8'h12; bus.s0_data = 16'hABCD;
    tick();
    idle_inputs();
    checks++;
    if (bus.vld !== 1'b0) begin errors++; $display("FAIL single_bypass vld=%b required=0", bus.vld); end
    tick();
    checks++;
    if (bus.vld !== 1'b1 || bus.addr !== 8'h12 || bus.data !== 16'hABCD) begin
      errors++;
      $display("FAIL single_out got vld=%b %h/%h required 1 12/abcd", bus.vld, bus.addr, bus.data);
    end
    tick();
    checks++;
    if (bus.vld !== 1'b0) begin errors++; $display("FAIL single_pulse vld=%b required=0", bus.vld); end
    drain("single");
  endtask

  task automatic contention_pair(input logic [15:0] d0, input logic [15:0] d1, input string name);
    bus.s0_vld = 1'b1; bus.s0_addr = 8'h05; bus.s0_data = d0;
    bus.s1_vld = 1'b1; bus.s1_addr = 8'h85; bus.s1_data = d1;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (bus.vld !== 1'b1 || bus.addr !== 8'h05 || bus.data !== d0) begin
      errors++;
      $display("FAIL %s_first got vld=%b %h/%h required 1 05/%h", name, bus.vld, bus.addr, bus.data, d0);
    end
    tick();
    checks++;
    if (bus.vld !== 1'b1 || bus.addr !== 8'h85 || bus.data !== d1) begin
      errors++;
      $display("FAIL %s_second got vld=%b %h/%h required 1 85/%h", name, bus.vld, bus.addr, bus.data, d1);
    end
    tick();
    checks++;
    if (bus.vld !== 1'b0) begin errors++; $display("FAIL %s_idle vld=%b required=0", name, bus.vld); end
  endtask

  task automatic test_contention();
    do_reset();
    contention_pair(16'h0501, 16'h8501, "cont1");
    contention_pair(16'h0502, 16'h8502, "cont2");
    drain("cont");
  endtask

  task automatic test_fill();
    int i0 = 0, i1 = 0, cyc = 0, max_lvl = 0;
    bit acc0, acc1, rdy_bad = 0, saw_full_rdy_low = 0;
    while ((i0 < 10 || i1 < 20) && cyc < 200) begin
      bus.s0_vld = (i0 < 10); bus.s0_addr = 8'h10; bus.s0_data = 16'(i0 + 1);
      bus.s1_vld = (i1 < 20); bus.s1_addr = 8'h90; bus.s1_data = 16'(16'h1000 + i1);
      acc0 = bus.s0_vld && (bus.s0_rdy === 1'b1);
      acc1 = bus.s1_vld && (bus.s1_rdy === 1'b1);
      tick();
      cyc++;
      if (acc0) i0++;
      if (acc1) i1++;
      if (int'(bus.s0_level) > max_lvl) max_lvl = int'(bus.s0_level);
      if (bus.s0_level == LW'(D)) begin
        if (bus.s0_rdy !== 1'b0) rdy_bad = 1;
        else saw_full_rdy_low = 1;
      end
    end
    idle_inputs();
    checks++;
    if (i0 != 10 || i1 != 20) begin
      errors++; $display("FAIL fill_timeout sent s0=%0d s1=%0d required 10/20", i0, i1);
    end
    checks++;
    if (max_lvl != D) begin errors++; $display("FAIL fill_max_level got=%0d required=%0d", max_lvl, D); end
    checks++;
    if (rdy_bad || !saw_full_rdy_low) begin
      errors++; $display("FAIL fill_rdy_when_full bad=%0d seen_low=%0d required 0/1", rdy_bad, saw_full_rdy_low);
    end
    drain("fill");
  endtask

  task automatic test_wrap();
    bit lvl_bad = 0, vld_bad = 0, rdy_bad = 0;
    for (int i = 0; i < 3 * D; i++) begin
      bus.s1_vld = 1'b1; bus.s1_addr = 8'hA0; bus.s1_data = 16'(16'h2000 + i);
      if (bus.s1_rdy !== 1'b1) rdy_bad = 1;
      tick();
      if (bus.s1_level > LW'(1)) lvl_bad = 1;
      if (i == 0 && bus.vld !== 1'b0) vld_bad = 1;
      if (i >= 1 && (bus.vld !== 1'b1 || bus.data !== 16'(16'h2000 + i - 1))) vld_bad = 1;
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.vld !== 1'b1 || bus.data !== 16'(16'h2000 + 3 * D - 1)) begin
      errors++; $display("FAIL wrap_last got vld=%b data=%h required 1/%h", bus.vld, bus.data, 16'(16'h2000 + 3 * D - 1));
    end
    tick();
    checks++;
    if (bus.vld !== 1'b0) begin errors++; $display("FAIL wrap_end vld=%b required=0", bus.vld); end
    checks++;
    if (lvl_bad) begin errors++; $display("FAIL wrap_level got=over1 required<=1"); end
    checks++;
    if (vld_bad) begin errors++; $display("FAIL wrap_stream got=gap_or_wrong required=1/cycle sequential"); end
    checks++;
    if (rdy_bad) begin errors++; $display("FAIL wrap_rdy got=0 required=1"); end
    drain("wrap");
  endtask

  task automatic test_midreset();
    bit vld_seen = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.s0_vld = 1'b1; bus.s0_addr = 8'h30; bus.s0_data = 16'(16'h3000 + i);
      bus.s1_vld = 1'b1; bus.s1_addr = 8'hB0; bus.s1_data = 16'(16'hB000 + i);
      tick();
    end
    idle_inputs();
    checks++;
    if (bus.s0_level !== LW'(3) || bus.s1_level !== LW'(3)) begin
      errors++; $display("FAIL mid_prefill got=%0d/%0d required=3/3", bus.s0_level, bus.s1_level);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (bus.s0_level !== '0 || bus.s1_level !== '0 || bus.vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got lvl=%0d/%0d vld=%b required 0/0 0", bus.s0_level, bus.s1_level, bus.vld);
    end
    checks++;
    if (bus.s0_rdy !== 1'b0 || bus.s1_rdy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_rdy got=%b%b required=00", bus.s0_rdy, bus.s1_rdy);
    end
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.vld !== 1'b0) vld_seen = 1;
    end
    checks++;
    if (vld_seen) begin errors++; $display("FAIL mid_stale_output got=vld1 required=0"); end
    checks++;
    if (bus.s0_rdy !== 1'b1 || bus.s1_rdy !== 1'b1) begin
      errors++; $display("FAIL mid_release_rdy got=%b%b required=11", bus.s0_rdy, bus.s1_rdy);
    end
  endtask

  initial begin
    bus.s0_vld = 1'b0; bus.s0_addr = '0; bus.s0_data = '0;
    bus.s1_vld = 1'b0; bus.s1_addr = '0; bus.s1_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_fill();
    test_wrap();
    test_midreset();
    drain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_ingress_arb.md
Name: switch_ingress_arb

Overview:
Ingress stage that sits directly upstream of the switch and drives its addr/data/vld inputs. It accepts packets from two independent sources over valid/ready handshakes and buffers each source in its own FIFO. A round-robin arbiter then merges them into the single no-backpressure addr/data/vld stream the switch consumes, at most one packet per clock.

Parameters:
ADDR_WIDTH, 8, width of packet address (matches switch addr).
DATA_WIDTH, 16, width of packet data (matches switch data).
FIFO_DEPTH, 4, entries per source FIFO; power of 2, >= 2.

Ports:
clk  input  1  single clock, all logic on rising edge.
rstn  input  1  synchronous active-low reset.
s0_vld  input  1  source 0 packet valid.
s0_rdy  output  1  source 0 ready; registered.
s0_addr  input  ADDR_WIDTH  source 0 address.
s0_data  input  DATA_WIDTH  source 0 data.
s1_vld  input  1  source 1 packet valid.
s1_rdy  output  1  source 1 ready; registered.
s1_addr  input  ADDR_WIDTH  source 1 address.
s1_data  input  DATA_WIDTH  source 1 data.
addr  output  ADDR_WIDTH  to switch addr; registered.
data  output  DATA_WIDTH  to switch data; registered.
vld  output  1  to switch vld; registered, one-cycle pulse per packet.
s0_level  output  $clog2(FIFO_DEPTH)+1  source 0 FIFO occupancy.
s1_level  output  $clog2(FIFO_DEPTH)+1  source 1 FIFO occupancy.

Behaviour:
- Reset (rstn=0 at a rising edge): both FIFOs are emptied (pointers=0, levels=0); vld=0, addr=0, data=0; s0_rdy=s1_rdy=0; last_grant=1, so source 0 wins the first contention. Reset applied mid-stream discards all buffered packets. A packet held in the output register is dropped, with vld=0 after that edge.
- sN_rdy: registered. On each non-reset edge it is loaded with (next levelN < FIFO_DEPTH). It therefore rises on the first edge after rstn goes high. There is no combinational path from any input to rdy.
- Push: at edge where sN_vld && sN_rdy, sN_addr/sN_data are written at the write pointer. Pointers wrap modulo FIFO_DEPTH; level width distinguishes full from empty.
- Arbitration, each edge, based on pre-edge levels:
  - Both FIFOs empty: no pop; vld<=0; addr/data hold previous values.
  - Exactly one non-empty: pop it.
  - Both non-empty: pop the source != last_grant.
  - On any pop: last_grant <= popped source; addr/data <= popped head; vld<=1.
- Same-edge push and pop on one FIFO: level unchanged, both operations take effect. A full FIFO (rdy=0) is never pushed even if popped that edge; rdy returns the following edge.
- Latency: a packet sampled at edge N into an empty FIFO, with no contention, is popped at edge N+1. vld/addr/data are valid in the cycle after N+1. An empty-to-output bypass is not permitted.
- Throughput: one output per cycle total. With both sources saturated, the grant strictly alternates s0,s1,s0,... Each source sustains 1 packet per 2 cycles, and rdy stays 0 while its FIFO is full.
- Downstream has no backpressure; every vld=1 cycle is a consumed packet. Packet order within a source is preserved, and no packet is duplicated or lost except by reset.
- Addr/data pass through unmodified; the block does no port decode.

Test Plan:
- Reset: rstn=0 for 2 edges with s0_vld=s1_vld=1 -> vld=0, addr=0, data=0, s0_rdy=s1_rdy=0, levels=0; after the first rstn=1 edge, rdy=1.
- Single packet: s0 sends addr=8'h12, data=16'hABCD at edge N -> vld=1 with addr=8'h12, data=16'hABCD in the cycle after N+1 only; vld=0 after.
- Contention: both sources push one packet at the same edge (s0 addr=8'h05, s1 addr=8'h85) after reset -> output order s0 then s1 on consecutive cycles; a second simultaneous pair also outputs s0 then s1 (alternation continues).
- Fill/backpressure: s0_vld held 1 with data 1..10 while s1 floods, for FIFO_DEPTH=4 -> s0_level reaches 4 and s0_rdy=0; no packet is lost; s0 data emerges as 1..10 in order, interleaved with s1.
- Wrap-around: stream 3*FIFO_DEPTH packets through s1 alone at full rate -> output is one packet per cycle after 2-cycle latency; data is sequential across pointer wrap; s1_level never exceeds 1.
- Reset mid-stream: both FIFOs at level 3, assert rstn=0 one edge -> levels=0, vld=0 next cycle; no pre-reset packet appears after reset release.
